// File: rtl/uart_pkg.sv
// Shared types and constants for the UART byte transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  localparam int UART_CLK_DIV_DEFAULT = 104;

  function automatic logic parity_bit(input int mode, input logic [7:0] b);
    return (mode == PAR_ODD) ? ~(^b) : (^b);
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period divider: counts 0..CLK_DIV-1 while enabled, pulses bit_done on the
// last cycle of each bit period.
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int CLK_DIV = UART_CLK_DIV_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic bit_done
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] TC = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear || !enable || (cnt == TC)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign bit_done = enable && !clear && (cnt == TC);

endmodule

// File: rtl/uart_byte_tx.sv
// UART frame serialiser: start, 8 data bits LSB first, optional parity, stop.
// Accepts one byte per frame through valid/ready; tx comes straight from a flop.
module uart_byte_tx
  import uart_pkg::*;
#(
  parameter int CLK_DIV = UART_CLK_DIV_DEFAULT,
  parameter int PARITY  = PAR_NONE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       ready_out,
  output logic       tx,
  output logic       busy
);

  // Unsupported parity codes fall back to no parity bit at all.
  localparam bit PAR_EN = (PARITY == PAR_EVEN) || (PARITY == PAR_ODD);

  tx_state_t  state;
  logic [7:0] shreg;
  logic [2:0] bit_idx;
  logic       par_q;
  logic       accept;
  logic       bit_done;

  assign accept    = (state == ST_IDLE) && valid_in;
  assign ready_out = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);

  uart_baud_cnt #(
    .CLK_DIV(CLK_DIV)
  ) u_baud (
    .clk     (clk),
    .rst     (rst),
    .clear   (accept),
    .enable  (busy),
    .bit_done(bit_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      shreg   <= '0;
      bit_idx <= '0;
      par_q   <= 1'b0;
      tx      <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          tx <= 1'b1;
          if (valid_in) begin
            shreg   <= data_in;
            par_q   <= parity_bit(PARITY, data_in);
            bit_idx <= '0;
            state   <= ST_START;
            tx      <= 1'b0;
          end
        end
        ST_START: begin
          if (bit_done) begin
            state <= ST_DATA;
            tx    <= shreg[0];
          end
        end
        ST_DATA: begin
          if (bit_done) begin
            if (bit_idx == 3'd7) begin
              if (PAR_EN) begin
                state <= ST_PARITY;
                tx    <= par_q;
              end else begin
                state <= ST_STOP;
                tx    <= 1'b1;
              end
            end else begin
              // shreg[0] always holds the bit currently on the line.
              bit_idx <= bit_idx + 3'd1;
              shreg   <= {1'b0, shreg[7:1]};
              tx      <= shreg[1];
            end
          end
        end
        ST_PARITY: begin
          if (bit_done) begin
            state <= ST_STOP;
            tx    <= 1'b1;
          end
        end
        ST_STOP: begin
          tx <= 1'b1;
          if (bit_done) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_byte_tx.sv
// Directed bench for uart_byte_tx: four instances cover no/even/odd parity at
// CLK_DIV=4 and the minimum divider of 2.
module tb_uart_byte_tx;

  logic       clk;
  logic       rst;
  logic [7:0] data_in [4];
  logic [3:0] valid_in;
  wire  [3:0] ready_out;
  wire  [3:0] tx;
  wire  [3:0] busy;

  int n_cmp = 0;
  int n_bad = 0;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    uart_byte_tx #(
      .CLK_DIV((g == 3) ? 2 : 4),
      .PARITY ((g == 3) ? 0 : g)
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .data_in  (data_in[g]),
      .valid_in (valid_in[g]),
      .ready_out(ready_out[g]),
      .tx       (tx[g]),
      .busy     (busy[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int         dut;
    logic [7:0] b;
    int         div;
    bit         has_par;
    bit         par;
    int         len;
    int         poke;
  } vec_t;

  vec_t vecs [7];

  // Accept on the next rising edge, then check every cycle of the frame.
  task automatic run_frame(input string tag, input int d, input logic [7:0] b, input int div,
                           input bit has_par, input bit par, input int len, input int poke);
    logic [10:0] fr;
    int idx;
    fr = '1;
    fr[0] = 1'b0;
    fr[8:1] = b;
    if (has_par) fr[9] = par;
    @(negedge clk);
    chk({tag, " ready_pre"}, ready_out[d], 1);
    data_in[d]  = b;
    valid_in[d] = 1'b1;
    @(posedge clk);
    #1;
    valid_in[d] = 1'b0;
    data_in[d]  = ~b;
    for (int k = 1; k <= len; k++) begin
      @(negedge clk);
      idx = (k - 1) / div;
      chk($sformatf("%s tx c%0d", tag, k), tx[d], fr[idx]);
      chk($sformatf("%s busy c%0d", tag, k), busy[d], 1);
      chk($sformatf("%s ready c%0d", tag, k), ready_out[d], 0);
      if (poke != 0 && k == poke) begin
        data_in[d]  = ~b;
        valid_in[d] = 1'b1;
      end
      if (poke != 0 && k == poke + 1) valid_in[d] = 1'b0;
    end
    @(negedge clk);
    chk({tag, " ready_end"}, ready_out[d], 1);
    chk({tag, " busy_end"}, busy[d], 0);
    chk({tag, " tx_end"}, tx[d], 1);
    if (poke != 0) begin
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        chk($sformatf("%s idle_busy %0d", tag, k), busy[d], 0);
        chk($sformatf("%s idle_tx %0d", tag, k), tx[d], 1);
      end
    end
  endtask

  initial begin
    logic [10:0] f1, f2;
    logic        rec [1:82];
    logic [7:0]  dec1, dec2;

    //          dut  byte   div par  pbit len poke
    vecs[0] = '{0, 8'h55, 4, 1'b0, 1'b0, 40, 0};
    vecs[1] = '{1, 8'h07, 4, 1'b1, 1'b1, 44, 0};
    vecs[2] = '{2, 8'h07, 4, 1'b1, 1'b0, 44, 0};
    vecs[3] = '{3, 8'h00, 2, 1'b0, 1'b0, 20, 0};
    vecs[4] = '{1, 8'h00, 4, 1'b1, 1'b0, 44, 0};
    vecs[5] = '{2, 8'hFF, 4, 1'b1, 1'b1, 44, 0};
    vecs[6] = '{0, 8'hF0, 4, 1'b0, 1'b0, 40, 10};

    rst      = 1'b0;
    valid_in = '1;
    for (int i = 0; i < 4; i++) data_in[i] = 8'hA5;
    #2 rst = 1'b1;
    #1;
    chk("reset tx", {28'd0, tx}, 32'hF);
    chk("reset ready", {28'd0, ready_out}, 32'hF);
    chk("reset busy", {28'd0, busy}, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset valid ignored busy", {28'd0, busy}, 32'h0);
    chk("reset valid ignored tx", {28'd0, tx}, 32'hF);
    valid_in = '0;
    @(negedge clk);
    rst = 1'b0;

    for (int v = 0; v < 7; v++) begin
      run_frame($sformatf("v%0d", v), vecs[v].dut, vecs[v].b, vecs[v].div,
                vecs[v].has_par, vecs[v].par, vecs[v].len, vecs[v].poke);
    end

    // Back-to-back with valid held high: A3 then 3C.
    f1 = '1; f1[0] = 1'b0; f1[8:1] = 8'hA3;
    f2 = '1; f2[0] = 1'b0; f2[8:1] = 8'h3C;
    @(negedge clk);
    data_in[0]  = 8'hA3;
    valid_in[0] = 1'b1;
    @(posedge clk);
    #1;
    data_in[0] = 8'h3C;
    for (int k = 1; k <= 82; k++) begin
      @(negedge clk);
      rec[k] = tx[0];
      if (k <= 40) begin
        chk($sformatf("b2b tx c%0d", k), tx[0], f1[(k - 1) / 4]);
      end else if (k == 41) begin
        chk("b2b gap tx", tx[0], 1);
        chk("b2b gap ready", ready_out[0], 1);
      end else if (k <= 81) begin
        chk($sformatf("b2b tx c%0d", k), tx[0], f2[(k - 42) / 4]);
        if (k == 42) chk("b2b second busy", busy[0], 1);
      end else begin
        chk("b2b end tx", tx[0], 1);
        chk("b2b end ready", ready_out[0], 1);
      end
      if (k == 42) valid_in[0] = 1'b0;
    end
    for (int i = 0; i < 8; i++) begin
      dec1[i] = rec[1 + 4 * (1 + i)];
      dec2[i] = rec[42 + 4 * (1 + i)];
    end
    chk("b2b decode1", dec1, 8'hA3);
    chk("b2b decode2", dec2, 8'h3C);

    // Asynchronous reset in the middle of data bit 3 of 0xF0 (bit 3 = 0).
    @(negedge clk);
    data_in[0]  = 8'hF0;
    valid_in[0] = 1'b1;
    @(posedge clk);
    #1;
    valid_in[0] = 1'b0;
    repeat (18) @(negedge clk);
    chk("arst pre tx", tx[0], 0);
    chk("arst pre busy", busy[0], 1);
    #1 rst = 1'b1;
    #1;
    chk("arst tx", tx[0], 1);
    chk("arst ready", ready_out[0], 1);
    chk("arst busy", busy[0], 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk($sformatf("arst idle tx %0d", k), tx[0], 1);
      chk($sformatf("arst idle busy %0d", k), busy[0], 0);
    end
    run_frame("arst_new", 0, 8'h81, 4, 1'b0, 1'b0, 40, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_byte_tx.md
Name: uart_byte_tx

Overview:
Serialises the 8-bit result byte produced by the top-level compute stage onto a single output pin as an asynchronous UART frame. The frame is start bit, 8 data bits LSB first, optional parity bit, and stop bit. It sits directly downstream of the result logic. The result byte enters through a valid/ready handshake, and the serial line drives one dedicated output bit. Bit timing comes from a fixed clock divider, so no external baud clock is needed.

Parameters:
- CLK_DIV, 104, clock cycles per serial bit; legal range >= 2.
- PARITY, 0, 0 = none, 1 = even, 2 = odd; any other value is treated as 0.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- data_in  input  8  byte to transmit; sampled only on an accept cycle.
- valid_in  input  1  producer has a byte on data_in.
- ready_out  output  1  block can accept a byte this cycle.
- tx  output  1  serial line; idles high.
- busy  output  1  a frame is in progress (any state other than IDLE).

Behaviour:
- Reset values (asynchronous, while rst=1): tx=1, ready_out=1, busy=0, state=IDLE, counters=0. valid_in is ignored while rst=1.
- Reset asserted mid-frame: tx returns to 1 immediately, without waiting for a clock edge. The frame is abandoned. The byte is not retransmitted.
- States: IDLE, START, DATA, PARITY, STOP.
- Accept rule: a byte is accepted on any rising edge where state=IDLE and valid_in=1.
  - ready_out=1 only in IDLE.
  - On accept, data_in is latched into the shift register and the state moves to START.
- Frame timing, with accept at edge T:
  - START drives tx=0 for cycles T+1..T+CLK_DIV.
  - DATA drives bit i (i=0..7, LSB first) for CLK_DIV cycles each.
  - PARITY (only if PARITY!=0) drives the parity bit for CLK_DIV cycles.
    - Even parity: XOR of the 8 latched bits.
    - Odd parity: inverse of that XOR.
  - STOP drives tx=1 for CLK_DIV cycles, then the state returns to IDLE.
- Frame length: 10*CLK_DIV cycles without parity, 11*CLK_DIV with parity.
- Back-to-back frames: ready_out is first high in the cycle after the last STOP cycle. If valid_in is held high, the next byte is accepted there. This gives a guaranteed minimum of 1 extra idle-high cycle between frames.
- Bit counter:
  - Width $clog2(CLK_DIV), counting 0..CLK_DIV-1.
  - It wraps to 0 and advances the bit/state on terminal count.
  - It is reset to 0 on accept.
- Data-bit index: 3 bits, 0..7. The DATA state is left when the index is 7 and the bit counter is at terminal count.
- Changes to data_in or valid_in while busy=1 have no effect. The latched byte alone is transmitted.
- tx is driven from a register (no combinational glitches). busy=~(state==IDLE).
- Latency: first start-bit cycle is 1 clock after the accept edge.

Decomposition:
- Shared package uart_pkg:
  - state enum tx_state_t {IDLE, START, DATA, PARITY, STOP}.
  - Parity constants PAR_NONE=0, PAR_EVEN=1, PAR_ODD=2.
  - Default divider constant UART_CLK_DIV_DEFAULT=104.
- One natural sub-module: uart_baud_cnt.
  - Parameter: CLK_DIV.
  - Inputs: clk, rst, clear, enable.
  - Output: a 1-cycle bit_done pulse at terminal count.
  - It is instantiated once; the FSM and shift register stay in uart_byte_tx.

Test Plan:
- CLK_DIV=4, PARITY=0; send 0x55 accepted at edge T:
  - tx=0 for T+1..T+4.
  - Then the bit sequence 1,0,1,0,1,0,1,0, each 4 cycles (T+5..T+36).
  - tx=1 for T+37..T+40.
  - ready_out=1 at T+41; busy=1 throughout T+1..T+40.
- CLK_DIV=4, PARITY=1, byte 0x07 (three ones):
  - Parity bit=1 on cycles T+37..T+40.
  - Stop bit T+41..T+44.
  - ready_out=1 at T+45.
  - Repeat with PARITY=2: parity bit=0.
- Back-to-back: valid_in held high with 0xA3 then 0x3C.
  - Second accept occurs exactly at T+41.
  - tx=1 on T+37..T+41.
  - Second start bit begins T+42.
  - Decoded bytes equal 0xA3 then 0x3C.
- Handshake ignore: during an in-flight frame of 0xF0, change data_in to 0x0F and pulse valid_in.
  - Transmitted bits still decode as 0xF0.
  - No second frame starts.
  - ready_out stays 0 until IDLE.
- Async reset mid-frame: assert rst during DATA bit 3 between clock edges.
  - tx=1, ready_out=1, busy=0 immediately, before the next edge.
  - After release, tx stays 1 until a new accept.
  - A new byte 0x81 then transmits correctly.
- Minimum divider CLK_DIV=2, byte 0x00:
  - Frame is 20 cycles.
  - tx low for cycles T+1..T+18, high for T+19..T+20.
  - ready_out=1 at T+21.
